rr_grant_scheduler: RTL and testbench

Round-robin scheduler that shares the 4-to-16 one-hot decode path among 16 requesters. Each cycle it sequences at most one owner, presents the owner's 4-bit index, and presents the matching registered one-hot grant vector. The index output drives the decoder select. The one-hot output gates requester enables directly. Ownership is held until the owner signals completion, drops its request, or exceeds a programmable hold limit.

---
 rtl/rr_grant_scheduler.sv | 94 +++++++++
 tb/tb_rr_grant_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for 16 requesters sharing one 4-to-16 decode path.
// Grants one owner at a time; ownership ends on done, request drop or hold limit.
module rr_grant_scheduler #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic        timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_reg;
    logic [3:0]  ptr_reg;
    logic [7:0]  cnt_reg;

    logic [15:0] req_rot;
    logic [3:0]  pick_off;
    logic [3:0]  pick_idx;
    logic [15:0] pick_onehot;
    logic        owner_req;
    logic        hold_hit;
    logic        release_now;

    // Rotate requests so bit 0 is the current highest-priority requester.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rot
            assign req_rot[gi]     = req[ptr_reg + 4'(gi)];
            assign pick_onehot[gi] = (pick_idx == 4'(gi));
        end
    endgenerate

    always_comb begin
        pick_off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = 4'(i);
            end
        end
    end

    assign pick_idx    = ptr_reg + pick_off;
    assign owner_req   = req[grant_idx];
    assign hold_hit    = (cnt_reg == HOLD_LAST);
    assign release_now = done | ~owner_req | hold_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 4'd0;
            cnt_reg      <= 8'd0;
            grant_valid  <= 1'b0;
            grant_idx    <= 4'h0;
            grant_onehot <= 16'h0000;
            timeout      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state_reg    <= GRANT;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick_idx;
                        grant_onehot <= pick_onehot;
                        cnt_reg      <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_reg    <= IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= 16'h0000;
                        ptr_reg      <= grant_idx + 4'd1;
                        // Only a pure hold-limit revocation is reported.
                        timeout      <= hold_hit & ~done & owner_req;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                        timeout <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler with a cycle-level ownership model
// plus directed literal expectations.
module tb_rr_grant_scheduler;

    localparam int HM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        done = 1'b0;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    rr_grant_scheduler #(.HOLD_MAX(HM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the resource, for how many cycles so far,
    // and where the next search begins.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_age = 0;
    bit m_timeout = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int pick;
        bit dropped;
        bit expired;
        if (rst) begin
            m_busy    <= 1'b0;
            m_owner   <= 0;
            m_ptr     <= 0;
            m_age     <= 0;
            m_timeout <= 1'b0;
        end else if (!m_busy) begin
            m_timeout <= 1'b0;
            pick = -1;
            for (int k = 15; k >= 0; k--) begin
                if (req[(m_ptr + k) % 16]) pick = (m_ptr + k) % 16;
            end
            if (pick >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= pick;
                m_age   <= 1;
            end
        end else begin
            dropped = !req[m_owner];
            expired = (m_age == HM);
            if (done || dropped || expired) begin
                m_busy    <= 1'b0;
                m_ptr     <= (m_owner + 1) % 16;
                m_timeout <= expired && !done && !dropped;
            end else begin
                m_age     <= m_age + 1;
                m_timeout <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] exp_oh;
        exp_oh = m_busy ? (16'h0001 << m_owner) : 16'h0000;
        chk("model_valid",   {15'h0, grant_valid}, {15'h0, m_busy});
        chk("model_idx",     {12'h0, grant_idx},   16'(m_owner));
        chk("model_onehot",  grant_onehot,         exp_oh);
        chk("model_timeout", {15'h0, timeout},     {15'h0, m_timeout});
    end

    task automatic cyc(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(negedge clk);
        $display("txn t=%0t req=%h done=%b -> valid=%b idx=%0d onehot=%h timeout=%b",
                 $time, r, d, grant_valid, grant_idx, grant_onehot, timeout);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [3:0] idx,
                              input logic [15:0] oh, input logic to);
        chk({name, "_valid"},   {15'h0, grant_valid}, {15'h0, v});
        chk({name, "_idx"},     {12'h0, grant_idx},   {12'h0, idx});
        chk({name, "_onehot"},  grant_onehot,         oh);
        chk({name, "_timeout"}, {15'h0, timeout},     {15'h0, to});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst = 1'b0;

        // Single requester, done in the third grant cycle
        cyc(16'h0001, 1'b0); expect_out("single_g1", 1'b1, 4'd0, 16'h0001, 1'b0);
        cyc(16'h0001, 1'b0); expect_out("single_g2", 1'b1, 4'd0, 16'h0001, 1'b0);
        cyc(16'h0001, 1'b0); expect_out("single_g3", 1'b1, 4'd0, 16'h0001, 1'b0);
        cyc(16'h0001, 1'b1); expect_out("single_dead", 1'b0, 4'd0, 16'h0000, 1'b0);
        cyc(16'h0001, 1'b0); expect_out("single_regrant", 1'b1, 4'd0, 16'h0001, 1'b0);

        // Asynchronous reset in the middle of a grant
        #3;
        rst = 1'b1;
        req = 16'($urandom_range(1, 65535));
        #1;
        expect_out("async_reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness between 0 and 15
        for (int n = 0; n < 2; n++) begin
            cyc(16'h8001, 1'b0); expect_out("fair_0", 1'b1, 4'd0, 16'h0001, 1'b0);
            cyc(16'h8001, 1'b1); expect_out("fair_dead0", 1'b0, 4'd0, 16'h0000, 1'b0);
            cyc(16'h8001, 1'b0); expect_out("fair_15", 1'b1, 4'd15, 16'h8000, 1'b0);
            cyc(16'h8001, 1'b1); expect_out("fair_dead15", 1'b0, 4'd15, 16'h0000, 1'b0);
        end

        // Pointer wrapped to 0 after 15
        cyc(16'h8004, 1'b0); expect_out("wrap_2", 1'b1, 4'd2, 16'h0004, 1'b0);
        cyc(16'h8004, 1'b1); expect_out("wrap_dead", 1'b0, 4'd2, 16'h0000, 1'b0);
        cyc(16'h8004, 1'b0); expect_out("wrap_15", 1'b1, 4'd15, 16'h8000, 1'b0);
        cyc(16'h0000, 1'b1); expect_out("wrap_rel", 1'b0, 4'd15, 16'h0000, 1'b0);

        // Hold limit revocation
        cyc(16'h0020, 1'b0); expect_out("to_g1", 1'b1, 4'd5, 16'h0020, 1'b0);
        cyc(16'h0020, 1'b0);
        cyc(16'h0020, 1'b0);
        cyc(16'h0020, 1'b0); expect_out("to_g4", 1'b1, 4'd5, 16'h0020, 1'b0);
        cyc(16'h0020, 1'b0); expect_out("to_pulse", 1'b0, 4'd5, 16'h0000, 1'b1);
        cyc(16'h0020, 1'b0); expect_out("to_regrant", 1'b1, 4'd5, 16'h0020, 1'b0);
        cyc(16'h0020, 1'b0);
        cyc(16'h0020, 1'b0);
        cyc(16'h0020, 1'b0); expect_out("to_done_g4", 1'b1, 4'd5, 16'h0020, 1'b0);
        cyc(16'h0020, 1'b1); expect_out("to_done_rel", 1'b0, 4'd5, 16'h0000, 1'b0);

        // Request drop by the owner
        cyc(16'h0080, 1'b0); expect_out("drop_g7", 1'b1, 4'd7, 16'h0080, 1'b0);
        cyc(16'h0280, 1'b0); expect_out("drop_hold7", 1'b1, 4'd7, 16'h0080, 1'b0);
        cyc(16'h0200, 1'b0); expect_out("drop_dead", 1'b0, 4'd7, 16'h0000, 1'b0);
        cyc(16'h0200, 1'b0); expect_out("drop_g9", 1'b1, 4'd9, 16'h0200, 1'b0);
        cyc(16'h0000, 1'b1); expect_out("drop_rel9", 1'b0, 4'd9, 16'h0000, 1'b0);
        cyc(16'h0000, 1'b1); expect_out("idle_done", 1'b0, 4'd9, 16'h0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
